// File: rtl/uart_rx_fifo_pkg.sv
// Shared sizing defaults and types for the UART receive FIFO.
// Width parameters on the modules default to these values.
package uart_rx_fifo_pkg;

  localparam int UART_FIFO_DEPTH  = 16;
  localparam int UART_FIFO_ADDR_W = 4;
  localparam int UART_FIFO_DATA_W = 8;
  localparam int UART_FIFO_THRESH = 8;
  localparam int UART_FIFO_CNT_W  = UART_FIFO_ADDR_W + 1;

  typedef logic [UART_FIFO_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / CPU bus-slave logic and the receive FIFO.
// master = receiver + bus logic side, slave = FIFO.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_FIFO_DATA_W,
  parameter int CNT_W  = UART_FIFO_CNT_W
);

  logic              rx_end;
  logic [DATA_W-1:0] rx_data;
  logic              rd_en;
  logic              flush;
  logic              ovr_clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overrun;
  logic              irq;

  modport master (
    output rx_end, rx_data, rd_en, flush, ovr_clr,
    input  rd_data, rd_valid, empty, full, count, overrun, irq
  );

  modport slave (
    input  rx_end, rx_data, rd_en, flush, ovr_clr,
    output rd_data, rd_valid, empty, full, count, overrun, irq
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered read port.
// The array itself is never reset; only the read register is.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = UART_FIFO_ADDR_W,
  parameter int DATA_W = UART_FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read register holds its value when no pop happens.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Same-address read and write returns the old entry (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: edge-detected capture, pops with 1-clk latency,
// registered level/flags, threshold irq and sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = UART_FIFO_ADDR_W,
  parameter int DATA_W = UART_FIFO_DATA_W,
  parameter int THRESH = UART_FIFO_THRESH
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;

  logic              rx_end_q,   rx_end_d;
  logic [ADDR_W-1:0] wptr_q,     wptr_d;
  logic [ADDR_W-1:0] rptr_q,     rptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              empty_q,    empty_d;
  logic              full_q,     full_d;
  logic              overrun_q,  overrun_d;
  logic              irq_q,      irq_d;
  logic              rd_valid_q, rd_valid_d;

  logic              wr;
  logic              do_wr;
  logic              do_rd;
  logic              ovr_set;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    wr      = bus.rx_end & ~rx_end_q;
    do_rd   = bus.rd_en & ~empty_q & ~bus.flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    do_wr   = wr & ~bus.flush & (~full_q | do_rd);
    ovr_set = wr & ~bus.flush & full_q & ~do_rd;

    rx_end_d   = bus.rx_end;
    rd_valid_d = do_rd;
    wptr_d     = do_wr ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d     = do_rd ? rptr_q + ADDR_W'(1) : rptr_q;
    count_d    = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    irq_d   = (count_d >= CNT_W'(THRESH));

    overrun_d = overrun_q;
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_end_q   <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rx_end_q   <= rx_end_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (do_wr),
    .waddr (wptr_q),
    .wdata (bus.rx_data),
    .re    (do_rd),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overrun  = overrun_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations checked with immediate assertions.
module tb_uart_rx_fifo;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  uart_rx_fifo_if bus_if ();

  uart_rx_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus_if.rx_data = b;
    bus_if.rx_end  = 1'b1;
    tick();
    bus_if.rx_end  = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(bus_if.rd_valid), 32'd1);
    chk({tag, "_dat"}, 32'(bus_if.rd_data), 32'(exp));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_data"},  32'(bus_if.rd_data),  32'h0);
    chk({tag, "_rd_valid"}, 32'(bus_if.rd_valid), 32'd0);
    chk({tag, "_count"},    32'(bus_if.count),    32'd0);
    chk({tag, "_empty"},    32'(bus_if.empty),    32'd1);
    chk({tag, "_full"},     32'(bus_if.full),     32'd0);
    chk({tag, "_overrun"},  32'(bus_if.overrun),  32'd0);
    chk({tag, "_irq"},      32'(bus_if.irq),      32'd0);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus_if.rx_end  = 1'b0;
    bus_if.rx_data = 8'h00;
    bus_if.rd_en   = 1'b0;
    bus_if.flush   = 1'b0;
    bus_if.ovr_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("rst");

    // 1: three single-cycle strobes, three back-to-back pops
    push(8'h41);
    push(8'h42);
    push(8'h43);
    chk("t1_count", 32'(bus_if.count), 32'd3);
    chk("t1_empty", 32'(bus_if.empty), 32'd0);
    pop_chk("t1_pop0", 8'h41);
    pop_chk("t1_pop1", 8'h42);
    pop_chk("t1_pop2", 8'h43);
    chk("t1_empty_after", 32'(bus_if.empty), 32'd1);
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    chk("t1_rd_empty_vld", 32'(bus_if.rd_valid), 32'd0);
    chk("t1_rd_empty_hold", 32'(bus_if.rd_data), 32'h43);

    // 2: strobe held high for 5 cycles gives a single entry
    bus_if.rx_data = 8'h55;
    bus_if.rx_end  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus_if.rx_end = 1'b0;
    tick();
    chk("t2_count", 32'(bus_if.count), 32'd1);
    pop_chk("t2_pop", 8'h55);
    chk("t2_empty", 32'(bus_if.empty), 32'd1);

    // 3: fill to full, overrun on 17th, drain in order
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 6) chk("t3_irq_cnt7", 32'(bus_if.irq), 32'd0);
      if (i == 7) chk("t3_irq_cnt8", 32'(bus_if.irq), 32'd1);
    end
    chk("t3_full", 32'(bus_if.full), 32'd1);
    chk("t3_count16", 32'(bus_if.count), 32'd16);
    chk("t3_ovr_before", 32'(bus_if.overrun), 32'd0);
    push(8'hFF);
    chk("t3_ovr", 32'(bus_if.overrun), 32'd1);
    chk("t3_count_drop", 32'(bus_if.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop_chk("t3_drain", 8'(i));
      if (i == 8) chk("t3_irq_cnt7_drain", 32'(bus_if.irq), 32'd0);
    end
    chk("t3_empty", 32'(bus_if.empty), 32'd1);
    chk("t3_ovr_sticky", 32'(bus_if.overrun), 32'd1);

    // 6a: flush with concurrent write; overrun left as is
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    chk("t6_count5", 32'(bus_if.count), 32'd5);
    bus_if.rx_data = 8'h22;
    bus_if.rx_end  = 1'b1;
    bus_if.flush   = 1'b1;
    tick();
    bus_if.rx_end = 1'b0;
    bus_if.flush  = 1'b0;
    chk("t6_flush_count", 32'(bus_if.count), 32'd0);
    chk("t6_flush_empty", 32'(bus_if.empty), 32'd1);
    chk("t6_flush_ovr", 32'(bus_if.overrun), 32'd1);
    tick();
    chk("t6_flush_count_hold", 32'(bus_if.count), 32'd0);
    bus_if.ovr_clr = 1'b1;
    tick();
    bus_if.ovr_clr = 1'b0;
    chk("t6_ovr_clr", 32'(bus_if.overrun), 32'd0);

    // 4: full FIFO, write and pop together
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    chk("t4_full", 32'(bus_if.full), 32'd1);
    bus_if.rx_data = 8'hAA;
    bus_if.rx_end  = 1'b1;
    bus_if.rd_en   = 1'b1;
    tick();
    bus_if.rx_end = 1'b0;
    bus_if.rd_en  = 1'b0;
    chk("t4_rd_vld", 32'(bus_if.rd_valid), 32'd1);
    chk("t4_rd_dat", 32'(bus_if.rd_data), 32'h30);
    chk("t4_count", 32'(bus_if.count), 32'd16);
    chk("t4_ovr", 32'(bus_if.overrun), 32'd0);
    tick();
    for (int i = 1; i < 16; i++) pop_chk("t4_drain", 8'h30 + 8'(i));
    pop_chk("t4_last", 8'hAA);
    chk("t4_empty", 32'(bus_if.empty), 32'd1);

    // 5: empty FIFO, write and pop together: no fall-through
    bus_if.rx_data = 8'h11;
    bus_if.rx_end  = 1'b1;
    bus_if.rd_en   = 1'b1;
    tick();
    bus_if.rx_end = 1'b0;
    bus_if.rd_en  = 1'b0;
    chk("t5_rd_vld", 32'(bus_if.rd_valid), 32'd0);
    chk("t5_count", 32'(bus_if.count), 32'd1);
    tick();
    pop_chk("t5_pop", 8'h11);

    // 6b: reset in the middle of a fill
    push(8'h71);
    push(8'h72);
    push(8'h73);
    pop_chk("t6_pre_rst", 8'h71);
    bus_if.rx_data = 8'h77;
    bus_if.rx_end  = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.rx_end = 1'b0;
    chk_reset_vals("t6_rst");
    tick();
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    chk("t6_post_rst_vld", 32'(bus_if.rd_valid), 32'd0);
    chk("t6_post_rst_cnt", 32'(bus_if.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
